ysyx_24100006_axi_sram: RTL and testbench

AXI4-Lite-style memory responder (subordinate) that serves the single-beat read and write transactions issued by the core's fetch and load/store units. It owns a word-organised SRAM array behind one shared port. It accepts one transaction at a time, inserts programmable wait states, and returns OKAY or error responses. It sits at the far end of the core's memory bus, in simulation tops and SoC-less builds.

---
 rtl/ysyx_24100006_axi_sram.sv | 241 ++++++++++++++++++++++++
 tb/tb_ysyx_24100006_axi_sram.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_axi_sram.sv
// Single-outstanding AXI4-Lite-style SRAM responder with programmable wait states.
// Define YSYX_24100006_SRAM_RAND_DELAY_EN to draw the per-transaction delay from an LFSR.
module ysyx_24100006_axi_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned FIXED_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,

    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic        axi_rlast,

    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [7:0]  axi_awlen,
    input  logic [2:0]  axi_awsize,

    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,

    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WAIT,
        RRESP,
        BRESP
    } state_t;

    state_t state, state_nxt;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      addr_q;
    logic [2:0]       size_q;
    logic [7:0]       len_q;
    logic             is_wr;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic [3:0]       cnt;
    logic [3:0]       delay;

    logic             ar_hs, aw_hs, w_hs;
    logic             access;
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             out_of_range;
    logic             bad_shape;
    logic [1:0]       resp_chk;

`ifdef YSYX_24100006_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;

    // Fibonacci form of x^8+x^6+x^5+x^4+1, free-running every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_comb begin
        delay = {1'b0, lfsr[2:0]};
    end
`else
    always_comb begin
        delay = 4'(FIXED_DELAY);
    end
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    state_nxt = WAIT;
                end else if (aw_hs && w_hs) begin
                    state_nxt = WAIT;
                end else if (aw_hs) begin
                    state_nxt = WDATA;
                end
            end
            WDATA: begin
                if (w_hs) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = is_wr ? BRESP : RRESP;
                end
            end
            RRESP: begin
                if (axi_rready) begin
                    state_nxt = IDLE;
                end
            end
            BRESP: begin
                if (axi_bready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; a pending AR blocks AW, and W is only taken alongside or after AW.
    always_comb begin
        axi_arready = (state == IDLE);
        axi_awready = (state == IDLE) && !axi_arvalid;
        axi_wready  = ((state == IDLE) && axi_awvalid && !axi_arvalid) || (state == WDATA);
        axi_rvalid  = (state == RRESP);
        axi_rlast   = (state == RRESP);
        axi_bvalid  = (state == BRESP);
    end

    always_comb begin
        ar_hs  = axi_arready && axi_arvalid;
        aw_hs  = axi_awready && axi_awvalid;
        w_hs   = axi_wready && axi_wvalid;
        access = (state == WAIT) && (cnt == '0);
    end

    // Base-aligned, so offset[1:0] equals the address lane bits.
    always_comb begin
        offset       = addr_q - ADDR_BASE;
        idx          = offset[IDX_W+1:2];
        out_of_range = (addr_q < ADDR_BASE) || ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));
        bad_shape    = (len_q != 8'd0)
                    || (size_q > 3'd2)
                    || ((size_q == 3'd1) && offset[0])
                    || ((size_q == 3'd2) && (offset[1:0] != 2'b00));
        if (out_of_range) begin
            resp_chk = RESP_DECERR;
        end else if (bad_shape) begin
            resp_chk = RESP_SLVERR;
        end else begin
            resp_chk = RESP_OKAY;
        end
    end

    // Transaction capture, delay countdown and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            size_q    <= '0;
            len_q     <= '0;
            is_wr     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt       <= '0;
            axi_rdata <= '0;
            axi_rresp <= RESP_OKAY;
            axi_bresp <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        addr_q <= axi_araddr;
                        size_q <= axi_arsize;
                        len_q  <= axi_arlen;
                        is_wr  <= 1'b0;
                        cnt    <= delay;
                    end else if (aw_hs) begin
                        addr_q  <= axi_awaddr;
                        size_q  <= axi_awsize;
                        len_q   <= axi_awlen;
                        is_wr   <= 1'b1;
                        wdata_q <= axi_wdata;
                        wstrb_q <= axi_wstrb;
                        cnt     <= delay;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        wdata_q <= axi_wdata;
                        wstrb_q <= axi_wstrb;
                        cnt     <= delay;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else if (is_wr) begin
                        axi_bresp <= resp_chk;
                    end else begin
                        axi_rresp <= resp_chk;
                        axi_rdata <= (resp_chk == RESP_OKAY) ? mem[idx] : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array is not reset; a reset forces IDLE, so an in-flight write never commits.
    always_ff @(posedge clk) begin
        if (access && is_wr && (resp_chk == RESP_OKAY)) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_axi_sram.sv
// Scoreboard bench for ysyx_24100006_axi_sram: expected responses are queued at issue
// and checked, together with response latency, when the R/B handshake fires.
module tb_ysyx_24100006_axi_sram;

    localparam int unsigned FD = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic        axi_rlast;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    ysyx_24100006_axi_sram #(
        .ADDR_BASE  (32'h8000_0000),
        .DEPTH_WORDS(1024),
        .FIXED_DELAY(FD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .axi_araddr (axi_araddr),
        .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_arlen  (axi_arlen),
        .axi_arsize (axi_arsize),
        .axi_rdata  (axi_rdata),
        .axi_rresp  (axi_rresp),
        .axi_rvalid (axi_rvalid),
        .axi_rready (axi_rready),
        .axi_rlast  (axi_rlast),
        .axi_awaddr (axi_awaddr),
        .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_awlen  (axi_awlen),
        .axi_awsize (axi_awsize),
        .axi_wdata  (axi_wdata),
        .axi_wstrb  (axi_wstrb),
        .axi_wvalid (axi_wvalid),
        .axi_wready (axi_wready),
        .axi_bresp  (axi_bresp),
        .axi_bvalid (axi_bvalid),
        .axi_bready (axi_bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_accept = 0;
    int rise_r = 0;
    int rise_b = 0;
    logic prev_rv = 1'b0;
    logic prev_bv = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: latency is measured from the accepting edge to the valid rise.
    always @(negedge clk) begin
        if (!reset) begin
            prev_rv = 1'b0;
            prev_bv = 1'b0;
        end else begin
            if (axi_rvalid && !prev_rv) rise_r = cyc;
            if (axi_bvalid && !prev_bv) rise_b = cyc;
            prev_rv = axi_rvalid;
            prev_bv = axi_bvalid;
            if (axi_rvalid && axi_rready) begin
                if (sb.size() == 0) begin
                    check("r_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("r_kind", 32'd1, {31'd0, mon_e.is_rd});
                    check("rdata", axi_rdata, mon_e.data);
                    check("rresp", {30'd0, axi_rresp}, {30'd0, mon_e.resp});
                    check("rlast", {31'd0, axi_rlast}, 32'd1);
                    check("r_lat", 32'(rise_r - last_accept), 32'(FD + 1));
                end
            end
            if (axi_bvalid && axi_bready) begin
                if (sb.size() == 0) begin
                    check("b_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("b_kind", 32'd0, {31'd0, mon_e.is_rd});
                    check("bresp", {30'd0, axi_bresp}, {30'd0, mon_e.resp});
                    check("b_lat", 32'(rise_b - last_accept), 32'(FD + 1));
                end
            end
        end
    end

    task automatic wait_hs(input string tag, input logic is_aw);
        int  n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (is_aw ? axi_awready : axi_arready) ok = 1'b1;
            n++;
        end
        if (!ok) check(tag, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        last_accept = cyc;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check(tag, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] sz, input logic [7:0] ln, input logic [1:0] rs);
        sb.push_back('{is_rd: 1'b0, data: 32'h0, resp: rs});
        @(posedge clk);
        #1;
        axi_awaddr  = a;
        axi_awsize  = sz;
        axi_awlen   = ln;
        axi_awvalid = 1'b1;
        axi_wdata   = d;
        axi_wstrb   = s;
        axi_wvalid  = 1'b1;
        wait_hs("aw_timeout", 1'b1);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        wait_done("b_timeout");
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] ln,
                      input logic [31:0] ed, input logic [1:0] rs);
        sb.push_back('{is_rd: 1'b1, data: ed, resp: rs});
        @(posedge clk);
        #1;
        axi_araddr  = a;
        axi_arsize  = sz;
        axi_arlen   = ln;
        axi_arvalid = 1'b1;
        wait_hs("ar_timeout", 1'b0);
        axi_arvalid = 1'b0;
        wait_done("r_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset       = 1'b0;
        axi_araddr  = '0;
        axi_arvalid = 1'b0;
        axi_arlen   = '0;
        axi_arsize  = '0;
        axi_rready  = 1'b1;
        axi_awaddr  = '0;
        axi_awvalid = 1'b0;
        axi_awlen   = '0;
        axi_awsize  = '0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b1;

        #12;
        check("rst_arready", {31'd0, axi_arready}, 32'd1);
        check("rst_awready", {31'd0, axi_awready}, 32'd1);
        check("rst_wready",  {31'd0, axi_wready},  32'd0);
        check("rst_rvalid",  {31'd0, axi_rvalid},  32'd0);
        check("rst_bvalid",  {31'd0, axi_bvalid},  32'd0);
        check("rst_rlast",   {31'd0, axi_rlast},   32'd0);
        check("rst_rdata",   axi_rdata, 32'd0);
        check("rst_rresp",   {30'd0, axi_rresp}, 32'd0);
        check("rst_bresp",   {30'd0, axi_bresp}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        wr(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 3'd2, 8'd0, 2'b00);
        rd(32'h8000_0010, 3'd2, 8'd0, 32'hDEAD_BEEF, 2'b00);
        wr(32'h8000_0011, 32'h0000_AB00, 4'b0010, 3'd0, 8'd0, 2'b00);
        rd(32'h8000_0010, 3'd2, 8'd0, 32'hDEAD_ABEF, 2'b00);
        rd(32'h8000_0012, 3'd1, 8'd0, 32'hDEAD_ABEF, 2'b00);
        rd(32'h8000_0011, 3'd0, 8'd0, 32'hDEAD_ABEF, 2'b00);

        wr(32'h8000_0000, 32'hCAFE_F00D, 4'b1111, 3'd2, 8'd0, 2'b00);
        wr(32'h8000_0002, 32'h1111_1111, 4'b1111, 3'd2, 8'd0, 2'b10);
        rd(32'h8000_0000, 3'd2, 8'd0, 32'hCAFE_F00D, 2'b00);
        wr(32'h8000_0000, 32'hFFFF_FFFF, 4'b0000, 3'd2, 8'd0, 2'b00);
        rd(32'h8000_0000, 3'd2, 8'd0, 32'hCAFE_F00D, 2'b00);
        wr(32'h8000_0000, 32'h2222_2222, 4'b1111, 3'd2, 8'd1, 2'b10);
        rd(32'h8000_0000, 3'd2, 8'd0, 32'hCAFE_F00D, 2'b00);

        rd(32'h7FFF_FFFC, 3'd2, 8'd0, 32'h0, 2'b11);
        rd(32'h7FFF_FFFD, 3'd2, 8'd0, 32'h0, 2'b11);
        rd(32'h8000_1000, 3'd2, 8'd0, 32'h0, 2'b11);
        rd(32'h8000_0010, 3'd2, 8'd3, 32'h0, 2'b10);
        rd(32'h8000_0011, 3'd1, 8'd0, 32'h0, 2'b10);
        rd(32'h8000_0010, 3'd3, 8'd0, 32'h0, 2'b10);
        wr(32'h7FFF_FFF0, 32'h3333_3333, 4'b1111, 3'd2, 8'd0, 2'b11);
        wr(32'h8000_0FFC, 32'h0BAD_CAFE, 4'b1111, 3'd2, 8'd0, 2'b00);
        rd(32'h8000_0FFC, 3'd2, 8'd0, 32'h0BAD_CAFE, 2'b00);

        // AR and AW presented together: read first, AW held off until the read completes.
        sb.push_back('{is_rd: 1'b1, data: 32'hDEAD_ABEF, resp: 2'b00});
        sb.push_back('{is_rd: 1'b0, data: 32'h0, resp: 2'b00});
        @(posedge clk);
        #1;
        axi_araddr  = 32'h8000_0010;
        axi_arsize  = 3'd2;
        axi_arlen   = 8'd0;
        axi_arvalid = 1'b1;
        axi_awaddr  = 32'h8000_0020;
        axi_awsize  = 3'd2;
        axi_awlen   = 8'd0;
        axi_awvalid = 1'b1;
        axi_wdata   = 32'h1122_3344;
        axi_wstrb   = 4'b1111;
        axi_wvalid  = 1'b1;
        @(negedge clk);
        check("both_arready", {31'd0, axi_arready}, 32'd1);
        check("both_awready", {31'd0, axi_awready}, 32'd0);
        check("both_wready",  {31'd0, axi_wready},  32'd0);
        @(posedge clk);
        #1;
        last_accept = cyc;
        axi_arvalid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            check("aw_held", {31'd0, axi_awready}, 32'd0);
            n++;
        end while (!(axi_rvalid && axi_rready) && n < 50);
        wait_hs("aw_after_ar", 1'b1);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        wait_done("both_timeout");
        rd(32'h8000_0020, 3'd2, 8'd0, 32'h1122_3344, 2'b00);

        // Back-pressure on R: response must hold and no new AR may be taken.
        @(posedge clk);
        #1;
        axi_rready = 1'b0;
        sb.push_back('{is_rd: 1'b1, data: 32'hDEAD_ABEF, resp: 2'b00});
        axi_araddr  = 32'h8000_0010;
        axi_arsize  = 3'd2;
        axi_arlen   = 8'd0;
        axi_arvalid = 1'b1;
        wait_hs("stall_ar", 1'b0);
        axi_arvalid = 1'b0;
        n = 0;
        while (!axi_rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_rvalid_seen", {31'd0, axi_rvalid}, 32'd1);
        @(posedge clk);
        #1;
        sb.push_back('{is_rd: 1'b1, data: 32'h1122_3344, resp: 2'b00});
        axi_araddr  = 32'h8000_0020;
        axi_arvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_rvalid",  {31'd0, axi_rvalid},  32'd1);
            check("stall_rdata",   axi_rdata, 32'hDEAD_ABEF);
            check("stall_rresp",   {30'd0, axi_rresp}, 32'd0);
            check("stall_arready", {31'd0, axi_arready}, 32'd0);
        end
        @(posedge clk);
        #1;
        axi_rready = 1'b1;
        wait_hs("ar_after_stall", 1'b0);
        axi_arvalid = 1'b0;
        wait_done("stall_timeout");

        // Reset during WAIT of a write: nothing commits, outputs clear at once.
        @(posedge clk);
        #1;
        axi_awaddr  = 32'h8000_0020;
        axi_awsize  = 3'd2;
        axi_awlen   = 8'd0;
        axi_awvalid = 1'b1;
        axi_wdata   = 32'h5566_7788;
        axi_wstrb   = 4'b1111;
        axi_wvalid  = 1'b1;
        wait_hs("rst_aw", 1'b1);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        reset = 1'b0;
        #1;
        check("arst_bvalid",  {31'd0, axi_bvalid},  32'd0);
        check("arst_rvalid",  {31'd0, axi_rvalid},  32'd0);
        check("arst_arready", {31'd0, axi_arready}, 32'd1);
        check("arst_rdata",   axi_rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("arst_held_bvalid", {31'd0, axi_bvalid}, 32'd0);
        reset = 1'b1;
        rd(32'h8000_0020, 3'd2, 8'd0, 32'h1122_3344, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
